// File: rtl/mmc_seq_pkg.sv
// Purpose: shared command codes, sub-layer indices and FSM state type for the MMC command sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mmc_seq_pkg;

    // Host command codes as carried on iREQ_CMD
    localparam logic [1:0] CMD_INIT  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;
    localparam logic [1:0] CMD_RSVD  = 2'd3;

    // Sub-layer slot indices on the per-sub buses
    localparam int SUB_INIT  = 0;
    localparam int SUB_READ  = 1;
    localparam int SUB_WRITE = 2;
    localparam int NUM_SUBS  = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_DISPATCH = 3'd2,
        ST_RUN      = 3'd3,
        ST_ABORT    = 3'd4,
        ST_GAP      = 3'd5,
        ST_END      = 3'd6
    } seq_state_t;

    // Map a command code to its sub-layer one-hot select; reserved maps to none
    function automatic logic [2:0] cmd_onehot(input logic [1:0] cmd);
        logic [2:0] oh;
        oh = 3'b000;
        case (cmd)
            CMD_INIT:  oh[SUB_INIT]  = 1'b1;
            CMD_READ:  oh[SUB_READ]  = 1'b1;
            CMD_WRITE: oh[SUB_WRITE] = 1'b1;
            default:   oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/mmc_seq_link_mux.sv
// Purpose: one-hot select of the active sub-layer onto the shared byte link, plus BUSY/VALID gating back.
// Latency: purely combinational, 0 cycles.
// Backpressure: unselected subs always see BUSY=1 and VALID=0; an all-zero select parks the link idle.
module mmc_seq_link_mux
    import mmc_seq_pkg::*;
(
    input  logic [2:0]  sel,
    input  logic [2:0]  sub_req,
    input  logic [2:0]  sub_cs,
    input  logic [23:0] sub_data,
    input  logic        mmc_busy,
    input  logic        mmc_valid,
    output logic        mmc_req,
    output logic        mmc_cs,
    output logic [7:0]  mmc_data,
    output logic [2:0]  sub_busy,
    output logic [2:0]  sub_valid
);

    // Forward the selected sub's request/CS/byte; with nothing selected the link idles (CS high, 0xFF)
    always_comb begin
        mmc_req  = 1'b0;
        mmc_cs   = 1'b1;
        mmc_data = 8'hff;
        for (int i = 0; i < NUM_SUBS; i++) begin
            if (sel[i]) begin
                mmc_req  = sub_req[i];
                mmc_cs   = sub_cs[i];
                mmc_data = sub_data[8*i +: 8];
            end
        end
    end

    assign sub_busy  = ~sel | {3{mmc_busy}};
    assign sub_valid = sel & {3{mmc_valid}};

endmodule

// File: rtl/mmc_cmd_layer_sequencer.sv
// Purpose: runs one MMC command sub-layer (INIT/READ/WRITE) at a time on a shared SPI byte link.
// Latency: iREQ to oSUB_START 2 cycles; oREQ_END P_GAP_CYCLES+1 cycles after the active sub's end pulse.
// Backpressure: iREQ is sampled only in IDLE (dropped while busy); optional RUN timeout via MMC_SEQ_TIMEOUT_EN.
module mmc_cmd_layer_sequencer
    import mmc_seq_pkg::*;
#(
    parameter int P_GAP_CYCLES = 8,
    parameter int P_BYTE_ADDR  = 1,
    parameter int P_TIMEOUT    = 1 << 20
)
(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iREQ,
    input  logic [1:0]  iREQ_CMD,
    input  logic [31:0] iREQ_ADDR,
    output logic        oREQ_BUSY,
    output logic        oREQ_END,
    output logic        oREQ_ERR,
    output logic        oINIT_DONE,
    output logic [2:0]  oSUB_START,
    output logic [31:0] oSUB_ADDR,
    output logic [2:0]  oSUB_RESET_SYNC,
    input  logic [2:0]  iSUB_END,
    input  logic [2:0]  iSUB_MMC_REQ,
    input  logic [2:0]  iSUB_MMC_CS,
    input  logic [23:0] iSUB_MMC_DATA,
    output logic [2:0]  oSUB_MMC_BUSY,
    output logic [2:0]  oSUB_MMC_VALID,
    output logic [7:0]  oSUB_MMC_DATA,
    output logic        oMMC_REQ,
    output logic        oMMC_CS,
    output logic [7:0]  oMMC_DATA,
    input  logic        iMMC_BUSY,
    input  logic        iMMC_VALID,
    input  logic [7:0]  iMMC_DATA
);

    localparam logic [7:0]  GAP_LAST     = 8'(P_GAP_CYCLES - 1);
    localparam logic [20:0] TIMEOUT_LAST = 21'(P_TIMEOUT - 1);

    if (P_GAP_CYCLES < 1 || P_GAP_CYCLES > 255) begin : g_bad_gap
        $error("P_GAP_CYCLES out of range 1..255");
    end
    if (P_TIMEOUT < 1 || P_TIMEOUT > (1 << 21)) begin : g_bad_timeout
        $error("P_TIMEOUT does not fit the 21-bit RUN counter");
    end

    seq_state_t  state_q, state_d;
    logic [1:0]  cmd_q;
    logic [31:0] addr_q;
    logic        err_q;
    logic        init_done_q;
    logic [7:0]  gap_cnt_q;
    logic [31:0] addr_conv;
    logic [2:0]  sel_oh;
    logic [2:0]  link_sel;
    logic        cmd_err;
    logic        sub_end;
    logic        timeout;

    assign addr_conv = (P_BYTE_ADDR != 0) ? {iREQ_ADDR[22:0], 9'h000} : iREQ_ADDR;
    assign sel_oh    = cmd_onehot(cmd_q);
    assign link_sel  = (state_q == ST_RUN) ? sel_oh : 3'b000;
    assign cmd_err   = (cmd_q == CMD_RSVD) || ((cmd_q != CMD_INIT) && !init_done_q);
    assign sub_end   = |(iSUB_END & sel_oh);

`ifdef MMC_SEQ_TIMEOUT_EN
    logic [20:0] run_cnt_q;

    // Count RUN cycles since dispatch so a hung sub-layer can be aborted
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            run_cnt_q <= '0;
        end else if (iRESET_SYNC || state_q == ST_DISPATCH) begin
            run_cnt_q <= '0;
        end else if (state_q == ST_RUN) begin
            run_cnt_q <= run_cnt_q + 21'd1;
        end
    end

    assign timeout = (run_cnt_q == TIMEOUT_LAST);
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic; a sub end beats a coincident timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (iREQ) state_d = ST_CHECK;
            ST_CHECK:    state_d = cmd_err ? ST_END : ST_DISPATCH;
            ST_DISPATCH: state_d = ST_RUN;
            ST_RUN: begin
                if (sub_end)      state_d = ST_GAP;
                else if (timeout) state_d = ST_ABORT;
            end
            ST_ABORT:    state_d = ST_GAP;
            ST_GAP:      if (gap_cnt_q == GAP_LAST) state_d = ST_END;
            ST_END:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // State, request latch, error flag, gap counter and sticky init-done
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_INIT;
            addr_q      <= '0;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
            gap_cnt_q   <= '0;
        end else if (iRESET_SYNC) begin
            state_q     <= ST_IDLE;
            cmd_q       <= CMD_INIT;
            addr_q      <= '0;
            err_q       <= 1'b0;
            init_done_q <= 1'b0;
            gap_cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && iREQ) begin
                cmd_q  <= iREQ_CMD;
                addr_q <= addr_conv;
                err_q  <= 1'b0;
            end
            if ((state_q == ST_CHECK && cmd_err) || state_q == ST_ABORT) begin
                err_q <= 1'b1;
            end
            gap_cnt_q <= (state_q == ST_GAP) ? gap_cnt_q + 8'd1 : 8'd0;
            // INIT outcome decides init-done both ways so a failed re-init drops it
            if (state_q == ST_END && cmd_q == CMD_INIT) begin
                init_done_q <= !err_q;
            end
        end
    end

    assign oREQ_BUSY       = (state_q != ST_IDLE);
    assign oREQ_END        = (state_q == ST_END);
    assign oREQ_ERR        = (state_q == ST_END) && err_q;
    assign oINIT_DONE      = init_done_q;
    assign oSUB_START      = (state_q == ST_DISPATCH) ? sel_oh : 3'b000;
    assign oSUB_ADDR       = addr_q;
    assign oSUB_RESET_SYNC = {3{iRESET_SYNC}} | ((state_q == ST_ABORT) ? sel_oh : 3'b000);
    assign oSUB_MMC_DATA   = iMMC_DATA;

    mmc_seq_link_mux u_link_mux (
        .sel       (link_sel),
        .sub_req   (iSUB_MMC_REQ),
        .sub_cs    (iSUB_MMC_CS),
        .sub_data  (iSUB_MMC_DATA),
        .mmc_busy  (iMMC_BUSY),
        .mmc_valid (iMMC_VALID),
        .mmc_req   (oMMC_REQ),
        .mmc_cs    (oMMC_CS),
        .mmc_data  (oMMC_DATA),
        .sub_busy  (oSUB_MMC_BUSY),
        .sub_valid (oSUB_MMC_VALID)
    );

endmodule
